mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// Shares one single-ported backing memory between the fetch stage (I-side, read-only) and the
// memory stage (D-side, load/store) of the 5-stage core. One transaction is outstanding at a time.
// D-side has priority over I-side, and a starvation counter bounds how long I-side waits.
// Core-facing i_ready/d_ready feed the hazard unit: while a requester's ready is low, it stalls.
// PARAMETERS
// AW            32  address width, byte addresses
// DW            32  data width; must be a multiple of 8
// STARVE_LIMIT  4   max consecutive D grants while i_req is pending; next grant goes to I
// PORTS
// clk         in   1      clock, rising edge
// rst         in   1      asynchronous active-low reset (0 = reset)
// i_req       in   1      fetch request; held with i_addr stable until i_ready or i_flush
// i_addr      in   AW     fetch address
// i_flush     in   1      pipeline redirect; cancels any in-flight fetch
// i_ready     out  1      fetch complete; i_rdata valid this cycle
// i_rdata     out  DW     fetched instruction
// d_req       in   1      data request; held with d_* inputs stable until d_ready
// d_we        in   1      1 = store, 0 = load
// d_addr      in   AW     data address
// d_wdata     in   DW     store data
// d_wstrb     in   DW/8   store byte enables
// d_ready     out  1      data access complete; d_rdata valid on loads
// d_rdata     out  DW     load data
// mem_req     out  1      memory request; held until mem_gnt
// mem_we      out  1      memory write
// mem_addr    out  AW     memory address
// mem_wdata   out  DW     memory write data
// mem_wstrb   out  DW/8   memory byte enables; 0 on reads
// mem_gnt     in   1      memory accepted the request
// mem_rvalid  in   1      response or write-ack; arrives at least 1 cycle after mem_gnt
// mem_rdata   in   DW     read data, valid when mem_rvalid is high
// busy        out  1      high when state != IDLE
// err         out  1      sticky: mem_rvalid seen outside WAIT/DRAIN
// BEHAVIOUR
// - Reset (async):
//   - state=IDLE, owner=NONE, starve_cnt=0, err=0.
//   - All mem_* outputs 0; i_ready=0, d_ready=0; i_rdata=0, d_rdata=0.
//   - A reset in mid-transaction aborts it. mem_req drops immediately. No ready is issued.
// - States: IDLE, REQ (mem_req=1, waiting for mem_gnt), WAIT (waiting for mem_rvalid),
//   DRAIN (waiting for mem_rvalid of a flushed fetch, then discarding it).
// - IDLE arbitration, evaluated every cycle:
//   - Grant D if d_req && !(i_req_eff && starve_cnt==STARVE_LIMIT).
//   - Otherwise grant I if i_req_eff. Here i_req_eff = i_req && !i_flush.
//   - On a grant, register addr/we/wdata/wstrb, set owner, and go to REQ. No grant: stay in IDLE.
// - starve_cnt: +1 (saturating) on a D grant while i_req_eff is high. Cleared on an I grant,
//   and cleared in IDLE when i_req_eff is low.
// - REQ -> WAIT on mem_gnt. mem_* outputs come only from registers (no combinational path
//   from core inputs to the memory side).
// - WAIT, on mem_rvalid, goes to IDLE in the same edge:
//   - owner I: i_ready=1, i_rdata=mem_rdata (combinational that cycle).
//   - owner D: d_ready=1; d_rdata=mem_rdata on loads, 0 on stores.
// - Minimum latency, with mem_gnt in the first REQ cycle and mem_rvalid on the next cycle:
//   request seen in cycle 0 -> ready in cycle 2. Next arbitration happens in cycle 3.
// - i_flush, by state and owner:
//   - IDLE: suppresses that cycle's I grant.
//   - REQ, owner I: mem_req stays high until mem_gnt, then DRAIN.
//   - WAIT, owner I: go to DRAIN.
//   - WAIT, owner I, same cycle as mem_rvalid: response is discarded, i_ready stays 0, go to IDLE.
//   - Owner D: no effect.
//   - DRAIN -> IDLE on mem_rvalid, never asserting i_ready.
// - i_ready and d_ready are single-cycle pulses and are never high together.
// - mem_rvalid in IDLE or REQ: ignored, and err is set (sticky until reset).
// - Simultaneous d_req and i_req with starve_cnt < STARVE_LIMIT: D wins.
// STRUCTURE
// - Package mem_arb_pkg holds:
//   - typedef enum arb_state_t {IDLE, REQ, WAIT, DRAIN}
//   - typedef enum owner_t {OWN_NONE, OWN_I, OWN_D}
//   - localparam default STARVE_LIMIT
// - Sub-module sat_counter (width $clog2(STARVE_LIMIT+1), inc/clr, saturates at STARVE_LIMIT).
// - Everything else is one FSM plus a request register bank.
// TESTING
// 1. Hold rst low, then release; i_req=1, i_addr=0x0; memory gnt=1, rvalid next cycle with
//    0x00500093 -> mem_req in cycle 1, i_ready=1 with i_rdata=0x00500093 in cycle 2.
// 2. d_req (load 0x1000) and i_req (0x4) in the same cycle -> D served first; I is granted
//    right after d_ready. The bus sees the 0x1000 read before the 0x4 read.
// 3. d_req held high for 6 transactions while i_req=1, STARVE_LIMIT=4 -> the 5th grant goes to I,
//    then D resumes.
// 4. Store 0xDEADBEEF, wstrb=0x3, to 0x2000 -> mem_we=1, mem_wstrb=0x3; d_ready on the ack;
//    d_rdata=0.
// 5. I-fetch in WAIT, then i_flush for 1 cycle, then rvalid 3 cycles later -> i_ready stays 0,
//    DRAIN -> IDLE. A new i_req to 0x40 completes normally.
// 6. Drop rst while in WAIT -> all outputs 0 immediately. A late rvalid in IDLE sets err=1.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the I-side/D-side memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } owner_t;

  // Consecutive D grants tolerated while a fetch is pending before I is forced in.
  localparam int DEFAULT_STARVE_LIMIT = 4;

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter used to track how long the fetch side has been starved.
module sat_counter #(
  parameter int LIMIT = 4,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat
);

  localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

  logic [W-1:0] r_count;

  // Clear wins over increment; increment stops once the limit is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != LIMIT_W)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_sat = (r_count == LIMIT_W);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data load/store.
// One transaction in flight; D has priority, bounded by a starvation counter for I.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  input  logic            i_flush,
  output logic            i_ready,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_wstrb,
  output logic            d_ready,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy,
  output logic            err
);

  arb_state_t      r_state;
  owner_t          r_owner;
  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [DW/8-1:0] r_wstrb;
  logic            r_flushed;
  logic            r_err;

  logic w_iReqEff;
  logic w_starveSat;
  logic w_grantD;
  logic w_grantI;
  logic w_cntInc;
  logic w_cntClr;
  logic w_respDone;

  // A flush in the same cycle as a fetch request cancels that request.
  assign w_iReqEff  = i_req && !i_flush;
  assign w_grantD   = (r_state == IDLE) && d_req && !(w_iReqEff && w_starveSat);
  assign w_grantI   = (r_state == IDLE) && !w_grantD && w_iReqEff;
  assign w_cntInc   = w_grantD && w_iReqEff;
  assign w_cntClr   = w_grantI || ((r_state == IDLE) && !w_iReqEff);
  assign w_respDone = (r_state == WAIT) && mem_rvalid;

  sat_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk   (clk),
    .rst_n (rst),
    .i_inc (w_cntInc),
    .i_clr (w_cntClr),
    .o_sat (w_starveSat)
  );

  // Arbitration, request capture and transaction sequencing in one state machine.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_owner   <= OWN_NONE;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_flushed <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (mem_rvalid && ((r_state == IDLE) || (r_state == REQ))) begin
        r_err <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_grantD) begin
            r_owner   <= OWN_D;
            r_we      <= d_we;
            r_addr    <= d_addr;
            r_wdata   <= d_we ? d_wdata : '0;
            r_wstrb   <= d_we ? d_wstrb : '0;
            r_flushed <= 1'b0;
            r_state   <= REQ;
          end else if (w_grantI) begin
            r_owner   <= OWN_I;
            r_we      <= 1'b0;
            r_addr    <= i_addr;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_flushed <= 1'b0;
            r_state   <= REQ;
          end
        end
        REQ: begin
          if ((r_owner == OWN_I) && i_flush) begin
            r_flushed <= 1'b1;
          end
          if (mem_gnt) begin
            if ((r_owner == OWN_I) && (r_flushed || i_flush)) begin
              r_state <= DRAIN;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            r_state <= IDLE;
            r_owner <= OWN_NONE;
          end else if ((r_owner == OWN_I) && i_flush) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (mem_rvalid) begin
            r_state <= IDLE;
            r_owner <= OWN_NONE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_owner <= OWN_NONE;
        end
      endcase
    end
  end

  assign mem_req   = (r_state == REQ);
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_wstrb = r_wstrb;

  assign i_ready = w_respDone && (r_owner == OWN_I) && !i_flush;
  assign d_ready = w_respDone && (r_owner == OWN_D);
  assign i_rdata = i_ready ? mem_rdata : '0;
  assign d_rdata = (d_ready && !r_we) ? mem_rdata : '0;

  assign busy = (r_state != IDLE);
  assign err  = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a simple auto-responding memory.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_flush = 1'b0;
  logic        i_ready;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_wstrb = '0;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic        autoMem = 1'b1;
  logic        pendResp = 1'b0;
  logic [31:0] pendAddr = '0;
  logic [31:0] busLog[$];

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy), .err(err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic logic [31:0] memFunc(input logic [31:0] a);
    return a + 32'h0050_0093;
  endfunction

  // Memory model: grants in the first REQ cycle, responds the cycle after the grant.
  always @(posedge clk) begin
    #1;
    if (autoMem) begin
      mem_rvalid = pendResp;
      mem_rdata  = pendResp ? memFunc(pendAddr) : 32'h0;
      pendResp   = 1'b0;
      mem_gnt    = mem_req;
      if (mem_req) begin
        pendResp = 1'b1;
        pendAddr = mem_addr;
        busLog.push_back(mem_addr);
      end
    end
  end

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    i_req = 1'b0; i_flush = 1'b0; d_req = 1'b0; d_we = 1'b0; d_wstrb = '0;
    autoMem = 1'b1; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; pendResp = 1'b0;
    busLog.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %0h expected 0", busy); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_mem_req: got %0h expected 0", mem_req); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL rst_err: got %0h expected 0", err); end
    checks++; if ({i_ready, d_ready} !== 2'b00) begin errors++; $display("[TB] FAIL rst_ready: got %0h expected 0", {i_ready, d_ready}); end
    checks++; if ({mem_addr, mem_wstrb, mem_we} !== 37'h0) begin errors++; $display("[TB] FAIL rst_mem_bus: got %0h expected 0", {mem_addr, mem_wstrb, mem_we}); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single_fetch();
    doReset();
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL fetch_mem_req_c1: got %0h expected 1", mem_req); end
    checks++; if (mem_wstrb !== 4'h0) begin errors++; $display("[TB] FAIL fetch_wstrb: got %0h expected 0", mem_wstrb); end
    checks++; if (i_ready !== 1'b0) begin errors++; $display("[TB] FAIL fetch_early_ready: got %0h expected 0", i_ready); end
    @(negedge clk);
    checks++; if (i_ready !== 1'b1) begin errors++; $display("[TB] FAIL fetch_ready_c2: got %0h expected 1", i_ready); end
    checks++; if (i_rdata !== 32'h0050_0093) begin errors++; $display("[TB] FAIL fetch_rdata: got %h expected 00500093", i_rdata); end
    i_req = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL fetch_idle_c3: got %0h expected 0", busy); end
  endtask

  task automatic test_priority();
    doReset();
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1000; i_req = 1'b1; i_addr = 32'h4;
    @(negedge clk);
    checks++; if (mem_addr !== 32'h1000) begin errors++; $display("[TB] FAIL prio_first_addr: got %h expected 00001000", mem_addr); end
    @(negedge clk);
    checks++; if ({d_ready, i_ready} !== 2'b10) begin errors++; $display("[TB] FAIL prio_d_ready: got %b expected 10", {d_ready, i_ready}); end
    checks++; if (d_rdata !== 32'h0050_1093) begin errors++; $display("[TB] FAIL prio_d_rdata: got %h expected 00501093", d_rdata); end
    d_req = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ((mem_req !== 1'b1) || (mem_addr !== 32'h4)) begin errors++; $display("[TB] FAIL prio_second_addr: got req %0h addr %h expected req 1 addr 00000004", mem_req, mem_addr); end
    @(negedge clk);
    checks++; if (i_ready !== 1'b1) begin errors++; $display("[TB] FAIL prio_i_ready: got %0h expected 1", i_ready); end
    checks++; if (i_rdata !== 32'h0050_0097) begin errors++; $display("[TB] FAIL prio_i_rdata: got %h expected 00500097", i_rdata); end
    i_req = 1'b0;
    checks++; if (busLog.size() !== 2) begin errors++; $display("[TB] FAIL prio_bus_count: got %0d expected 2", busLog.size()); end
    else if (busLog[0] !== 32'h1000) begin errors++; $display("[TB] FAIL prio_bus_order: got %h expected 00001000", busLog[0]); end
  endtask

  task automatic test_starvation();
    int seq[$];
    int expSeq[7] = '{1, 1, 1, 1, 2, 1, 1};
    int dCount = 0;
    logic iDone = 1'b0;
    doReset();
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; i_req = 1'b1; i_addr = 32'h8;
    for (int c = 0; c < 80 && !((dCount == 6) && iDone); c++) begin
      @(negedge clk);
      if (d_ready) begin
        seq.push_back(1);
        dCount++;
        if (dCount == 6) d_req = 1'b0;
        else d_addr = 32'h3000 + 32'(dCount * 4);
      end
      if (i_ready) begin
        seq.push_back(2);
        iDone = 1'b1;
        i_req = 1'b0;
      end
    end
    d_req = 1'b0; i_req = 1'b0;
    checks++; if (seq.size() !== 7) begin errors++; $display("[TB] FAIL starve_count: got %0d expected 7", seq.size()); end
    else begin
      for (int k = 0; k < 7; k++) begin
        checks++; if (seq[k] !== expSeq[k]) begin errors++; $display("[TB] FAIL starve_order[%0d]: got %0d expected %0d", k, seq[k], expSeq[k]); end
      end
    end
    checks++; if ((busLog.size() < 6) || (busLog[4] !== 32'h8) || (busLog[5] !== 32'h3010)) begin
      errors++; $display("[TB] FAIL starve_bus: got %0d entries expected I at 00000008 then D at 00003010", busLog.size());
    end
  endtask

  task automatic test_store();
    doReset();
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'h3;
    @(negedge clk);
    checks++; if ({mem_we, mem_wstrb} !== 5'b1_0011) begin errors++; $display("[TB] FAIL store_we_strb: got %b expected 10011", {mem_we, mem_wstrb}); end
    checks++; if ((mem_addr !== 32'h2000) || (mem_wdata !== 32'hDEAD_BEEF)) begin errors++; $display("[TB] FAIL store_bus: got %h/%h expected 00002000/deadbeef", mem_addr, mem_wdata); end
    @(negedge clk);
    checks++; if (d_ready !== 1'b1) begin errors++; $display("[TB] FAIL store_ready: got %0h expected 1", d_ready); end
    checks++; if (d_rdata !== 32'h0) begin errors++; $display("[TB] FAIL store_rdata: got %h expected 00000000", d_rdata); end
    d_req = 1'b0; d_we = 1'b0; d_wstrb = '0;
  endtask

  task automatic test_flush();
    int lat = 0;
    logic [31:0] got = '0;
    doReset();
    autoMem = 1'b0;
    @(negedge clk);
    i_req = 1'b1; i_flush = 1'b1; i_addr = 32'h10;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_idle_grant: got %0h expected 0", busy); end
    i_flush = 1'b0; i_addr = 32'h20;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL flush_req: got %0h expected 1", mem_req); end
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0; i_flush = 1'b1; i_req = 1'b0;
    @(negedge clk);
    i_flush = 1'b0;
    checks++; if ((busy !== 1'b1) || (i_ready !== 1'b0)) begin errors++; $display("[TB] FAIL flush_drain: got busy %0h ready %0h expected 1 0", busy, i_ready); end
    @(negedge clk);
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
    #1;
    checks++; if (i_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_discard: got %0h expected 0", i_ready); end
    @(negedge clk);
    mem_rvalid = 1'b0;
    checks++; if ({busy, err} !== 2'b00) begin errors++; $display("[TB] FAIL flush_back_idle: got %b expected 00", {busy, err}); end
    autoMem = 1'b1;
    i_req = 1'b1; i_addr = 32'h40;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (i_ready) begin
        lat = c; got = i_rdata;
        break;
      end
    end
    i_req = 1'b0;
    checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL flush_refetch_latency: got %0d expected 2", lat); end
    checks++; if (got !== 32'h0050_00D3) begin errors++; $display("[TB] FAIL flush_refetch_rdata: got %h expected 005000d3", got); end
  endtask

  task automatic test_reset_abort();
    doReset();
    autoMem = 1'b0;
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h80;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL abort_req_pre: got %0h expected 1", mem_req); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({mem_req, mem_addr} !== 33'h0) begin errors++; $display("[TB] FAIL abort_req_drop: got %h expected 0", {mem_req, mem_addr}); end
    i_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h84;
    @(negedge clk);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    checks++; if ((busy !== 1'b1) || (mem_req !== 1'b0)) begin errors++; $display("[TB] FAIL abort_wait: got busy %0h req %0h expected 1 0", busy, mem_req); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({busy, i_ready, d_ready, i_rdata, err, mem_addr} !== 68'h0) begin errors++; $display("[TB] FAIL abort_outputs: got %h expected 0", {busy, i_ready, d_ready, i_rdata, err, mem_addr}); end
    i_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'h2222_2222;
    #1;
    checks++; if (i_ready !== 1'b0) begin errors++; $display("[TB] FAIL late_rvalid_ready: got %0h expected 0", i_ready); end
    @(negedge clk);
    mem_rvalid = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL late_rvalid_err: got %0h expected 1", err); end
    @(negedge clk);
    checks++; if ({err, busy} !== 2'b10) begin errors++; $display("[TB] FAIL err_sticky: got %b expected 10", {err, busy}); end
  endtask

  // Run each scenario in order, then report.
  initial begin
    $display("[TB] starting mem_port_arbiter bench");
    test_reset();
    test_single_fetch();
    test_priority();
    test_starvation();
    test_store();
    test_flush();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
